// File: rtl/sprite_compositor_if.sv
// Sprite memory bus: per-channel sprite ROM address/data plus the shared palette lookup.
//   rom_addr  NUM_SPR*ADDR_W  channel i at [ADDR_W*i +: ADDR_W], driven by the compositor
//   rom_q     NUM_SPR*IDX_W   channel i ROM data, valid ROM_LAT cycles after rom_addr
//   pal_idx   IDX_W           winning palette index (combinational)
//   pal_rgb   12              palette colour returned combinationally for pal_idx
interface sprite_compositor_if #(
   parameter int NUM_SPR = 4,
   parameter int ADDR_W  = 14,
   parameter int IDX_W   = 4
);
   logic [NUM_SPR*ADDR_W-1:0] rom_addr;
   logic [NUM_SPR*IDX_W-1:0]  rom_q;
   logic [IDX_W-1:0]          pal_idx;
   logic [11:0]               pal_rgb;

   modport master (output rom_addr, output pal_idx, input rom_q, input pal_rgb);
   modport slave  (input rom_addr, input pal_idx, output rom_q, output pal_rgb);
endinterface

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor for the VGA path. Composites NUM_SPR sprite channels over a
// background colour, resolves priority (channel 0 highest) and transparency, looks up a
// shared palette and registers 4:4:4 RGB with a fixed latency of ROM_LAT+1 cycles.
// Reports per-frame sprite collisions.
// Ports:
//   vga_clk, reset_n       pixel clock, synchronous active-low reset
//   frame_start            1-cycle pulse at start of vertical blank
//   DrawX, DrawY           current pixel coordinate
//   spr_x, spr_y           requested top-left per sprite, channel i at [10i +: 10]
//   spr_en, spr_flip       requested enable / horizontal mirror per sprite
//   bg_rgb                 background colour {r,g,b}
//   mem                    sprite ROM + palette bus (master side)
//   red, green, blue       registered pixel colour
//   coll_status            collision flags of the previous frame
module sprite_compositor #(
   parameter int NUM_SPR    = 4,
   parameter int SPR_W      = 100,
   parameter int SPR_H      = 80,
   parameter int ADDR_W     = 14,
   parameter int IDX_W      = 4,
   parameter int ROM_LAT    = 1,
   parameter int TRANSP_IDX = 0,
   parameter int NUM_FRAMES = 2,
   parameter int ANIM_DIV   = 8
) (
   input  logic                    vga_clk,
   input  logic                    reset_n,
   input  logic                    frame_start,
   input  logic [9:0]              DrawX,
   input  logic [9:0]              DrawY,
   input  logic [NUM_SPR*10-1:0]   spr_x,
   input  logic [NUM_SPR*10-1:0]   spr_y,
   input  logic [NUM_SPR-1:0]      spr_en,
   input  logic [NUM_SPR-1:0]      spr_flip,
   input  logic [11:0]             bg_rgb,
   sprite_compositor_if.master     mem,
   output logic [3:0]              red,
   output logic [3:0]              green,
   output logic [3:0]              blue,
   output logic [NUM_SPR-1:0]      coll_status
);

   localparam int FC_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int AF_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

   // Active (shadow) sprite registers, loaded only on frame_start to avoid tearing
   logic [NUM_SPR*10-1:0] act_x, act_y;
   logic [NUM_SPR-1:0]    act_en, act_flip;

   logic [FC_W-1:0]   fc;
   logic [AF_W-1:0]   anim_frame;
   logic [ADDR_W-1:0] base;

   logic              hit_u  [NUM_SPR];
   logic [ADDR_W-1:0] addr_u [NUM_SPR];
   logic [NUM_SPR-1:0] hit_vec;

   logic [NUM_SPR-1:0] hit_pipe [ROM_LAT];
   logic [11:0]        bg_pipe  [ROM_LAT];
   logic [NUM_SPR-1:0] hit_d;
   logic [11:0]        bg_d;

   logic [NUM_SPR-1:0] opaque;
   logic               multi;
   logic               any_opaque;
   logic [IDX_W-1:0]   win_idx;
   logic [NUM_SPR-1:0] coll_acc;

   assign base = ADDR_W'(anim_frame) * ADDR_W'(SPR_W * SPR_H);

   // Stage 0: hit test and ROM address per channel. Bounds are compared in 11 bits so a
   // sprite near the right edge cannot wrap around to low DrawX values; sprites whose
   // origin is off-screen are never hit at all.
   for (genvar i = 0; i < NUM_SPR; i++) begin : g_ch
      logic [9:0]        x, y;
      logic [10:0]       xs, ys;
      logic              in_x, in_y;
      logic [ADDR_W-1:0] col, colm, row;

      assign x    = act_x[i*10 +: 10];
      assign y    = act_y[i*10 +: 10];
      assign xs   = {1'b0, x};
      assign ys   = {1'b0, y};
      assign in_x = (x < 10'd640) && ({1'b0, DrawX} >= xs) &&
                    ({1'b0, DrawX} <= xs + 11'(SPR_W - 1));
      assign in_y = (y < 10'd480) && ({1'b0, DrawY} >= ys) &&
                    ({1'b0, DrawY} <= ys + 11'(SPR_H - 1));
      assign hit_u[i] = act_en[i] && in_x && in_y;

      assign col  = ADDR_W'(DrawX) - ADDR_W'(x);
      assign colm = act_flip[i] ? (ADDR_W'(SPR_W - 1) - col) : col;
      assign row  = ADDR_W'(DrawY) - ADDR_W'(y);
      assign addr_u[i] = hit_u[i] ? (base + row * ADDR_W'(SPR_W) + colm) : '0;
   end

   always_comb begin
      hit_vec      = '0;
      mem.rom_addr = '0;
      for (int i = 0; i < NUM_SPR; i++) begin
         hit_vec[i] = hit_u[i];
         mem.rom_addr[i*ADDR_W +: ADDR_W] = addr_u[i];
      end
   end

   // Shadow registers and animation counter
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         act_x      <= '0;
         act_y      <= '0;
         act_en     <= '0;
         act_flip   <= '0;
         fc         <= '0;
         anim_frame <= '0;
      end else if (frame_start) begin
         act_x    <= spr_x;
         act_y    <= spr_y;
         act_en   <= spr_en;
         act_flip <= spr_flip;
         if (fc == FC_W'(ANIM_DIV - 1)) begin
            fc         <= '0;
            anim_frame <= (anim_frame == AF_W'(NUM_FRAMES - 1)) ? '0 : anim_frame + 1'b1;
         end else begin
            fc <= fc + 1'b1;
         end
      end
   end

   // Delay hit flags and background so they line up with rom_q
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         for (int k = 0; k < ROM_LAT; k++) begin
            hit_pipe[k] <= '0;
            bg_pipe[k]  <= '0;
         end
      end else begin
         hit_pipe[0] <= hit_vec;
         bg_pipe[0]  <= bg_rgb;
         for (int k = 1; k < ROM_LAT; k++) begin
            hit_pipe[k] <= hit_pipe[k-1];
            bg_pipe[k]  <= bg_pipe[k-1];
         end
      end
   end

   assign hit_d = hit_pipe[ROM_LAT-1];
   assign bg_d  = bg_pipe[ROM_LAT-1];

   // Resolve: scan from lowest priority upward so channel 0 overrides everything
   always_comb begin
      opaque  = '0;
      win_idx = IDX_W'(TRANSP_IDX);
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         opaque[i] = hit_d[i] && (mem.rom_q[i*IDX_W +: IDX_W] != IDX_W'(TRANSP_IDX));
         if (opaque[i])
            win_idx = mem.rom_q[i*IDX_W +: IDX_W];
      end
   end

   assign any_opaque  = |opaque;
   assign multi       = (opaque & (opaque - 1'b1)) != '0;
   assign mem.pal_idx = win_idx;

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         {red, green, blue} <= '0;
      end else begin
         {red, green, blue} <= any_opaque ? mem.pal_rgb : bg_d;
      end
   end

   // A collision in the frame_start cycle itself belongs to the new frame
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         coll_acc    <= '0;
         coll_status <= '0;
      end else if (frame_start) begin
         coll_status <= coll_acc;
         coll_acc    <= multi ? opaque : '0;
      end else if (multi) begin
         coll_acc <= coll_acc | opaque;
      end
   end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: hit/address generation, flip, priority,
// transparency, collision reporting, shadow registers, animation base and reset.
module tb_sprite_compositor;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic        frame_start;
   logic [9:0]  DrawX, DrawY;
   logic [39:0] spr_x, spr_y;
   logic [3:0]  spr_en, spr_flip;
   logic [11:0] bg_rgb;
   logic [3:0]  red, green, blue;
   logic [3:0]  coll_status;
   logic [3:0]  q_val [4];

   int n_checks = 0;
   int n_errors = 0;
   int fs_count = 0;

   sprite_compositor_if #(.NUM_SPR(4), .ADDR_W(14), .IDX_W(4)) mem_bus ();

   assign mem_bus.rom_q   = {q_val[3], q_val[2], q_val[1], q_val[0]};
   assign mem_bus.pal_rgb = {mem_bus.pal_idx, 4'hF, mem_bus.pal_idx};

   sprite_compositor dut (
      .vga_clk     (vga_clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .spr_x       (spr_x),
      .spr_y       (spr_y),
      .spr_en      (spr_en),
      .spr_flip    (spr_flip),
      .bg_rgb      (bg_rgb),
      .mem         (mem_bus.master),
      .red         (red),
      .green       (green),
      .blue        (blue),
      .coll_status (coll_status)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_fs();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      fs_count++;
   endtask

   task automatic set_spr(input int i, input int x, input int y, input logic en, input logic flip);
      spr_x[i*10 +: 10] = 10'(x);
      spr_y[i*10 +: 10] = 10'(y);
      spr_en[i]   = en;
      spr_flip[i] = flip;
   endtask

   function automatic logic [13:0] addr(input int i);
      return mem_bus.rom_addr[i*14 +: 14];
   endfunction

   function automatic logic [11:0] rgb();
      return {red, green, blue};
   endfunction

   task automatic pix(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; frame_start = 1'b0;
      DrawX = '0; DrawY = '0;
      spr_x = '0; spr_y = '0; spr_en = '0; spr_flip = '0;
      bg_rgb = '0;
      for (int i = 0; i < 4; i++) q_val[i] = 4'd0;

      // reset and background
      repeat (3) tick();
      check("rst_rgb", rgb(), 12'h000);
      bg_rgb = 12'h123;
      reset_n = 1'b1;
      tick(); tick();
      check("bg_after_rst", rgb(), 12'h123);
      check("rom_addr_idle", mem_bus.rom_addr, 56'h0);

      // single sprite: visible only after frame_start
      set_spr(0, 10, 20, 1'b1, 1'b0);
      q_val[0] = 4'd3;
      pix(10, 20);
      tick(); tick();
      check("pre_fs_bg", rgb(), 12'h123);
      pulse_fs();
      pix(10, 20);
      check("addr0_tl", addr(0), 14'd0);
      tick();
      check("pal_idx_s0", mem_bus.pal_idx, 4'd3);
      tick();
      check("rgb_s0", rgb(), 12'h3F3);
      pix(109, 99);
      check("addr0_br", addr(0), 14'd7999);
      pix(109, 100);
      check("addr0_below", addr(0), 14'd0);
      pix(110, 99);
      check("addr0_right", addr(0), 14'd0);
      tick(); tick();
      check("rgb_right_bg", rgb(), 12'h123);

      // horizontal flip and transparency
      spr_flip[0] = 1'b1;
      pulse_fs();
      pix(10, 20);
      check("addr0_flip", addr(0), 14'd99);
      pix(109, 21);
      check("addr0_flip_r1", addr(0), 14'd100);
      q_val[0] = 4'd0;
      pix(10, 20);
      tick();
      check("pal_idx_transp", mem_bus.pal_idx, 4'd0);
      tick();
      check("rgb_transp_bg", rgb(), 12'h123);

      // overlap, priority and collision
      spr_flip[0] = 1'b0;
      set_spr(1, 50, 20, 1'b1, 1'b0);
      q_val[0] = 4'd3; q_val[1] = 4'd5;
      pulse_fs();
      check("coll_none", coll_status, 4'b0000);
      pix(60, 30);
      check("addr0_ovl", addr(0), 14'd1050);
      check("addr1_ovl", addr(1), 14'd1010);
      tick();
      check("pal_idx_prio", mem_bus.pal_idx, 4'd3);
      tick();
      check("rgb_prio", rgb(), 12'h3F3);
      pix(0, 0);
      tick();
      pulse_fs();
      check("coll_set", coll_status, 4'b0011);
      q_val[0] = 4'd0;
      pix(60, 30);
      tick();
      check("pal_idx_s1", mem_bus.pal_idx, 4'd5);
      tick();
      check("rgb_s1", rgb(), 12'h5F5);
      pix(0, 0);
      tick();
      pulse_fs();
      check("coll_clear", coll_status, 4'b0000);

      // shadow registers and animation base
      q_val[0] = 4'd3;
      spr_en[1] = 1'b0;
      spr_x[9:0] = 10'd200;
      pix(11, 20);
      check("shadow_x", addr(0), 14'd1);
      while (fs_count < 8) pulse_fs();
      pix(200, 20);
      check("anim_base", addr(0), 14'd8000);
      pix(299, 99);
      check("anim_br", addr(0), 14'd15999);
      pix(11, 20);
      check("old_pos_gone", addr(0), 14'd0);
      while (fs_count < 16) pulse_fs();
      pix(201, 20);
      check("anim_wrap", addr(0), 14'd1);

      // off-screen origins never hit; partial sprites clip
      set_spr(2, 1000, 20, 1'b1, 1'b0);
      set_spr(3, 0, 480, 1'b1, 1'b0);
      pulse_fs();
      pix(1000, 20);
      check("x1000_a", addr(2), 14'd0);
      pix(1023, 20);
      check("x1000_b", addr(2), 14'd0);
      pix(50, 20);
      check("x1000_wrap", addr(2), 14'd0);
      pix(0, 480);
      check("y480_a", addr(3), 14'd0);
      pix(0, 500);
      check("y480_b", addr(3), 14'd0);
      set_spr(3, 600, 450, 1'b1, 1'b0);
      pulse_fs();
      pix(639, 479);
      check("clip_addr", addr(3), 14'd2939);

      // reset in the middle of a visible sprite line
      q_val[3] = 4'd7;
      tick();
      check("pal_idx_s3", mem_bus.pal_idx, 4'd7);
      tick();
      check("rgb_s3", rgb(), 12'h7F7);
      reset_n = 1'b0;
      tick();
      check("rgb_midrst", rgb(), 12'h000);
      reset_n = 1'b1;
      #1;
      check("addr3_post_rst", addr(3), 14'd0);
      tick(); tick();
      check("rgb_post_rst", rgb(), 12'h123);
      check("coll_post_rst", coll_status, 4'b0000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
